// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment display controller.
// Captures a binary word on an accepted load, converts it to BCD with an
// iterative double dabble (one bit per clk), then time-multiplexes the stored
// digits onto a shared segment bus with optional leading-zero blanking.
module seg7_scan_display #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned DIGITS         = 5,
    parameter int unsigned SCAN_DIV       = 16,
    parameter bit          SIGNED         = 1'b1,
    parameter bit          BLANK_LZ       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en,
    output logic              neg,
    output logic              overflow
);

    localparam int unsigned NBCD   = (DATA_W * 3) / 10 + 1;
    localparam int unsigned BCD_W  = NBCD * 4;
    localparam int unsigned DISP_W = DIGITS * 4;
    localparam int unsigned NCOPY  = (DIGITS < NBCD) ? DIGITS : NBCD;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_POL = {DIGITS{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                accept_c, shift_c, commit_c;

    logic [DATA_W-1:0]   mag_q, mag_in;
    logic [BCD_W-1:0]    bcd_q, bcd_adj, bcd_shift;
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_q;

    logic [DISP_W-1:0]   disp_q, disp_d, disp_nx;
    logic                ovf_d;

    logic [SCAN_DIV-1:0] scan_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   nz_c, onehot_c;
    logic [3:0]          digit_c;
    logic [6:0]          seg_d;
    logic                any_c;

    // Segment pattern for one BCD digit, gfedcba active high; non-decimal blank.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        shift_c  = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    accept_c = 1'b1;
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                shift_c = 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    commit_c = 1'b1;
                    state_d  = S_UPDATE;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Magnitude of the incoming word; the most negative value wraps to its own
    // unsigned magnitude, so no special case is needed.
    always_comb begin
        mag_in = (SIGNED && value[DATA_W-1]) ? DATA_W'(-value) : value;
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NBCD; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_shift = (bcd_adj << 1) | BCD_W'(mag_q[DATA_W-1]);
    end

    // Digits to publish and overflow flag, taken from the final shift result.
    always_comb begin
        disp_d = '0;
        ovf_d  = 1'b0;
        for (int unsigned i = 0; i < NCOPY; i++) begin
            disp_d[i*4 +: 4] = bcd_shift[i*4 +: 4];
        end
        for (int unsigned i = DIGITS; i < NBCD; i++) begin
            ovf_d = ovf_d | (|bcd_shift[i*4 +: 4]);
        end
    end

    // Conversion shift registers and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            sign_q <= 1'b0;
        end else if (accept_c) begin
            mag_q  <= mag_in;
            bcd_q  <= '0;
            cnt_q  <= '0;
            sign_q <= SIGNED && value[DATA_W-1];
        end else if (shift_c) begin
            mag_q  <= mag_q << 1;
            bcd_q  <= bcd_shift;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Display registers and status, published on entry to UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q   <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (commit_c) begin
                disp_q   <= disp_d;
                neg      <= sign_q && (disp_d != '0);
                overflow <= ovf_d;
            end
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_UPDATE);
        end
    end

    // Next scan index, blanking mask and segment pattern for the next cycle.
    always_comb begin
        idx_d = idx_q;
        if (&scan_q) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        disp_nx = commit_c ? disp_d : disp_q;
        any_c   = 1'b0;
        nz_c    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            any_c   = any_c | (|disp_nx[i*4 +: 4]);
            nz_c[i] = any_c;
        end
        digit_c  = disp_nx[idx_d*4 +: 4];
        onehot_c = DIGITS'(1) << idx_d;
        if (BLANK_LZ && (idx_d != '0) && !nz_c[idx_d]) begin
            seg_d = 7'h00;
        end else begin
            seg_d = decode(digit_c);
        end
    end

    // Scan counter and registered digit/segment drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg    <= SEG_POL ^ 7'h3F;
            dig_en <= DIG_POL ^ DIGITS'(1);
        end else begin
            scan_q <= scan_q + SCAN_DIV'(1);
            idx_q  <= idx_d;
            seg    <= SEG_POL ^ seg_d;
            dig_en <= DIG_POL ^ onehot_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display: two instances share stimulus,
// A = 5 digits signed active-high, B = 4 digits unsigned active-low.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;

    logic       busy_a, done_a, neg_a, overflow_a;
    logic [6:0] seg_a;
    logic [4:0] dig_en_a;
    logic       busy_b, done_b, neg_b, overflow_b;
    logic [6:0] seg_b;
    logic [3:0] dig_en_b;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    // Reference display state: displayed magnitude and flags per instance.
    int exp_disp_a = 0;
    int exp_disp_b = 0;
    bit exp_neg_a  = 1'b0;
    bit exp_ovf_b  = 1'b0;

    seg7_scan_display #(
        .DATA_W(16), .DIGITS(5), .SCAN_DIV(2),
        .SIGNED(1'b1), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_a), .done(done_a), .seg(seg_a), .dig_en(dig_en_a),
        .neg(neg_a), .overflow(overflow_a)
    );

    seg7_scan_display #(
        .DATA_W(16), .DIGITS(4), .SCAN_DIV(2),
        .SIGNED(1'b0), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_b), .done(done_b), .seg(seg_b), .dig_en(dig_en_b),
        .neg(neg_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    // Clocks since reset; the scan index advances every 4 of these.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic int pow10(input int n);
        int p = 1;
        for (int j = 0; j < n; j++) p = p * 10;
        return p;
    endfunction

    // Expected active-high pattern for digit position idx of a displayed number.
    function automatic logic [6:0] exp_seg(input int disp, input int idx);
        logic [6:0] tab [10];
        int p;
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        p = pow10(idx);
        if (idx > 0 && disp < p) return 7'h00;
        return tab[(disp / p) % 10];
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        ntests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || neg_a !== 1'b0 || overflow_a !== 1'b0) begin
            nfail++;
            $display("FAIL reset_status_a: got busy=%b done=%b neg=%b ovf=%b want 0000",
                     busy_a, done_a, neg_a, overflow_a);
        end
        ntests++;
        if (dig_en_a !== 5'b00001 || seg_a !== 7'h3F) begin
            nfail++;
            $display("FAIL reset_scan_a: got dig_en=%b seg=%h want 00001 3f", dig_en_a, seg_a);
        end
        ntests++;
        if (dig_en_b !== 4'b1110 || seg_b !== 7'h40 || busy_b !== 1'b0 || overflow_b !== 1'b0) begin
            nfail++;
            $display("FAIL reset_b: got dig_en=%b seg=%h busy=%b ovf=%b want 1110 40 0 0",
                     dig_en_b, seg_b, busy_b, overflow_b);
        end
        rst = 1'b0;
    endtask

    // One conversion: latency, busy length, display hold while busy, flags, full scan.
    task automatic test_conversion(input logic [15:0] v, input string tag);
        int mag, new_a, new_b, old_a, old_b, lat_a, lat_b, busy_n, done_n, ia, ib;
        logic [6:0] ea, eb;
        mag   = v[15] ? 65536 - int'(v) : int'(v);
        new_a = mag;
        new_b = int'(v) % 10000;
        old_a = exp_disp_a;
        old_b = exp_disp_b;
        value = v; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        value = 16'($urandom);
        lat_a = -1; lat_b = -1; busy_n = 0; done_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy_a) busy_n++;
            if (done_a) begin
                done_n++;
                if (lat_a < 0) lat_a = k;
            end
            if (done_b && lat_b < 0) lat_b = k;
            ia = (cyc / 4) % 5;
            ib = (cyc / 4) % 4;
            ea = exp_seg((k >= 16) ? new_a : old_a, ia);
            eb = ~exp_seg((k >= 16) ? new_b : old_b, ib);
            ntests++;
            if (seg_a !== ea || seg_b !== eb) begin
                nfail++;
                $display("FAIL %s hold_k%0d: got seg_a=%h seg_b=%h want %h %h", tag, k, seg_a, seg_b, ea, eb);
            end
            if (k > 0 && !busy_a) break;
        end
        exp_disp_a = new_a;
        exp_neg_a  = v[15] && (mag != 0);
        exp_disp_b = new_b;
        exp_ovf_b  = int'(v) >= 10000;
        ntests++;
        if (lat_a != 16 || lat_b != 16 || busy_n != 17 || done_n != 1) begin
            nfail++;
            $display("FAIL %s timing: got lat_a=%0d lat_b=%0d busy=%0d done=%0d want 16 16 17 1",
                     tag, lat_a, lat_b, busy_n, done_n);
        end
        ntests++;
        if (neg_a !== exp_neg_a || overflow_a !== 1'b0) begin
            nfail++;
            $display("FAIL %s flags_a: got neg=%b ovf=%b want %b 0", tag, neg_a, overflow_a, exp_neg_a);
        end
        ntests++;
        if (neg_b !== 1'b0 || overflow_b !== exp_ovf_b) begin
            nfail++;
            $display("FAIL %s flags_b: got neg=%b ovf=%b want 0 %b", tag, neg_b, overflow_b, exp_ovf_b);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            ia = (cyc / 4) % 5;
            ib = (cyc / 4) % 4;
            ntests++;
            if (dig_en_a !== 5'(1 << ia) || seg_a !== exp_seg(exp_disp_a, ia)) begin
                nfail++;
                $display("FAIL %s scan_a: got dig_en=%b seg=%h want %b %h", tag, dig_en_a, seg_a,
                         5'(1 << ia), exp_seg(exp_disp_a, ia));
            end
            ntests++;
            if (dig_en_b !== ~4'(1 << ib) || seg_b !== ~exp_seg(exp_disp_b, ib)) begin
                nfail++;
                $display("FAIL %s scan_b: got dig_en=%b seg=%h want %b %h", tag, dig_en_b, seg_b,
                         ~4'(1 << ib), ~exp_seg(exp_disp_b, ib));
            end
        end
    endtask

    // load held high with a new value every cycle: one capture per 18 clocks.
    task automatic test_load_held();
        logic [15:0] cap;
        int mag;
        bit exp_done;
        cap = 16'd0;
        load = 1'b1;
        for (int k = 0; k < 54; k++) begin
            value = 16'($urandom);
            if (k % 18 == 0) cap = value;
            @(posedge clk);
            #1;
            exp_done = (k % 18 == 16);
            ntests++;
            if (done_a !== exp_done || done_b !== exp_done) begin
                nfail++;
                $display("FAIL held_done_k%0d: got a=%b b=%b want %b", k, done_a, done_b, exp_done);
            end
            if (exp_done) begin
                mag = cap[15] ? 65536 - int'(cap) : int'(cap);
                ntests++;
                if (neg_a !== (cap[15] && mag != 0) || overflow_b !== (int'(cap) >= 10000) ||
                    seg_a !== exp_seg(mag, (cyc / 4) % 5)) begin
                    nfail++;
                    $display("FAIL held_value_%h: got neg=%b ovf_b=%b seg_a=%h want %b %b %h", cap,
                             neg_a, overflow_b, seg_a, cap[15] && mag != 0, int'(cap) >= 10000,
                             exp_seg(mag, (cyc / 4) % 5));
                end
                exp_disp_a = mag;
                exp_neg_a  = cap[15] && (mag != 0);
                exp_disp_b = int'(cap) % 10000;
                exp_ovf_b  = int'(cap) >= 10000;
            end
        end
        load = 1'b0;
    endtask

    // Reset at CONV cycle 8: abort, no done, display back to "0".
    task automatic test_reset_midconv();
        int done_n, ia, ib;
        value = 16'd4321; load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_disp_a = 0; exp_disp_b = 0; exp_neg_a = 1'b0; exp_ovf_b = 1'b0;
        ntests++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || done_a !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_busy: got busy_a=%b busy_b=%b done=%b want 0 0 0", busy_a, busy_b, done_a);
        end
        done_n = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done_a || done_b) done_n++;
            ia = (cyc / 4) % 5;
            ib = (cyc / 4) % 4;
            ntests++;
            if (seg_a !== exp_seg(0, ia) || seg_b !== ~exp_seg(0, ib) || neg_a !== 1'b0) begin
                nfail++;
                $display("FAIL midrst_display: got seg_a=%h seg_b=%h neg=%b want %h %h 0",
                         seg_a, seg_b, neg_a, exp_seg(0, ia), ~exp_seg(0, ib));
            end
        end
        ntests++;
        if (done_n != 0) begin
            nfail++;
            $display("FAIL midrst_done: got %0d pulses want 0", done_n);
        end
    endtask

    initial begin
        test_reset();
        test_conversion(16'd1234, "dec1234");
        test_conversion(16'hFFFF, "minus1");
        test_conversion(16'h8000, "most_neg");
        test_conversion(16'd9999, "dec9999");
        test_conversion(16'd0, "zero");
        test_conversion(16'd10000, "dec10000");
        test_conversion(16'hFFF6, "minus10");
        test_conversion(16'h7FFF, "max_pos");
        test_conversion(16'd100, "dec100");
        for (int r = 0; r < 12; r++) begin
            test_conversion(16'($urandom), "random");
        end
        test_load_held();
        test_conversion(16'd42, "after_held");
        test_reset_midconv();
        test_conversion(16'd1234, "recover");
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
